// File: rtl/dht_pkg.sv
// rtl/dht_pkg.sv - DHT11/DHT22 poller shared types, mode constants and time helpers
//
// Contents:
//   dht_state_e     - poller FSM state encoding (exposed on o_state)
//   MODE_DHT11/22   - values of the i_mode input
//   START_MS_*      - host start-pulse length per sensor type
//   clks_per_us()   - clock cycles per 1 us tick (never less than 1)
//   ms_to_us()      - millisecond constant expressed in 1 us ticks
package dht_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START_LO  = 3'd1,
    ST_START_REL = 3'd2,
    ST_RESP_LO   = 3'd3,
    ST_RESP_HI   = 3'd4,
    ST_BIT_LO    = 3'd5,
    ST_BIT_HI    = 3'd6,
    ST_CHECK     = 3'd7
  } dht_state_e;

  localparam logic MODE_DHT11 = 1'b0;
  localparam logic MODE_DHT22 = 1'b1;

  localparam int unsigned START_MS_DHT11 = 20;
  localparam int unsigned START_MS_DHT22 = 2;
  localparam int unsigned US_PER_MS      = 1000;

  // A clock slower than 1 MHz cannot resolve 1 us; clamp so the tick fires every cycle.
  function automatic int unsigned clks_per_us(input int unsigned clk_hz);
    int unsigned n;
    n = clk_hz / 1_000_000;
    return (n == 0) ? 1 : n;
  endfunction

  function automatic logic [31:0] ms_to_us(input int unsigned ms);
    return 32'(ms * US_PER_MS);
  endfunction

endpackage

// File: rtl/dht_tick.sv
// rtl/dht_tick.sv - 1 us timebase enable derived from the system clock
//
// Ports:
//   i_clk    in   system clock, CLK_HZ
//   i_rst_n  in   asynchronous active-low reset
//   o_tick   out  one-cycle enable once per microsecond
module dht_tick
  import dht_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_tick
);

  localparam int unsigned DIV  = clks_per_us(CLK_HZ);
  localparam logic [31:0] LAST = 32'(DIV - 1);

  logic [31:0] cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt    <= '0;
      o_tick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt    <= '0;
      o_tick <= 1'b1;
    end else begin
      cnt    <= cnt + 32'd1;
      o_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/dht_poll.sv
// rtl/dht_poll.sv - single-wire DHT11/DHT22 temperature/humidity poller
//
// Ports:
//   i_clk      in     system clock, CLK_HZ
//   i_rst_n    in     asynchronous active-low reset
//   i_mode     in     0 = DHT11, 1 = DHT22 (latched when a transaction starts)
//   i_start    in     one-cycle request for an immediate transaction
//   io_data    inout  sensor bus: pulled low or released, never driven high
//   o_humi     out    humidity (DHT11 %RH, DHT22 0.1 %RH)
//   o_temp     out    temperature, two's complement (DHT11 degC, DHT22 0.1 degC)
//   o_valid    out    strobe: o_humi/o_temp updated
//   o_crc_err  out    strobe: checksum mismatch, outputs held
//   o_timeout  out    strobe: sensor phase took too long, outputs held
//   o_busy     out    transaction in progress
//   o_state    out    current FSM state
module dht_poll
  import dht_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned POLL_MS    = 2000,
  parameter int unsigned TIMEOUT_US = 200,
  parameter int unsigned BIT1_US    = 50
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_mode,
  input  logic        i_start,
  inout  wire         io_data,
  output logic [15:0] o_humi,
  output logic [15:0] o_temp,
  output logic        o_valid,
  output logic        o_crc_err,
  output logic        o_timeout,
  output logic        o_busy,
  output logic [2:0]  o_state
);

  localparam logic [31:0] POLL_US    = ms_to_us(POLL_MS);
  localparam logic [31:0] START11_US = ms_to_us(START_MS_DHT11);
  localparam logic [31:0] START22_US = ms_to_us(START_MS_DHT22);
  localparam logic [31:0] TO_US      = 32'(TIMEOUT_US);
  localparam logic [31:0] B1_US      = 32'(BIT1_US);

  logic        tick;
  dht_state_e  state;
  logic [31:0] tmr;
  logic        drive_low;
  logic        mode_q;
  logic [5:0]  bit_cnt;
  logic [39:0] shreg;
  logic        sync1, sync2, prev;

  dht_tick #(.CLK_HZ(CLK_HZ)) u_tick (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .o_tick  (tick)
  );

  // drive_low is cleared by the asynchronous reset, so the bus is released at once.
  assign io_data = drive_low ? 1'b0 : 1'bz;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= io_data;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  logic fall, rise;
  assign fall = prev & ~sync2;
  assign rise = ~prev & sync2;

  logic [7:0] b4, b3, b2, b1, b0, sum;
  assign {b4, b3, b2, b1, b0} = shreg;
  assign sum = b4 + b3 + b2 + b1;

  logic [15:0] mag22, temp22, humi_next, temp_next;
  assign mag22     = {1'b0, b2[6:0], b1};
  assign temp22    = b2[7] ? (16'd0 - mag22) : {b2, b1};
  assign humi_next = (mode_q == MODE_DHT22) ? {b4, b3} : {8'h00, b4};
  assign temp_next = (mode_q == MODE_DHT22) ? temp22 : {{8{b2[7]}}, b2};

  logic [31:0] start_us;
  assign start_us = (mode_q == MODE_DHT11) ? START11_US : START22_US;

  // One timer serves every state: it restarts on each state change, so in IDLE it is
  // the poll counter, in START_LO the pulse timer, in BIT_HI the pulse width, and in
  // the sensor-driven states the timeout.
  logic poll_due, timed_out, sensor_phase, adv;
  assign poll_due     = (POLL_MS != 0) && (tmr >= POLL_US);
  assign timed_out    = tmr >= TO_US;
  assign sensor_phase = (state >= ST_START_REL) && (state <= ST_BIT_HI);

  // Bus edge that moves the current state forward.
  always_comb begin
    adv = 1'b0;
    case (state)
      ST_START_REL, ST_RESP_HI, ST_BIT_HI: adv = fall;
      ST_RESP_LO, ST_BIT_LO:               adv = rise;
      default:                             adv = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      tmr       <= '0;
      drive_low <= 1'b0;
      mode_q    <= MODE_DHT11;
      bit_cnt   <= '0;
      shreg     <= '0;
      o_humi    <= '0;
      o_temp    <= '0;
      o_valid   <= 1'b0;
      o_crc_err <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      o_valid   <= 1'b0;
      o_crc_err <= 1'b0;
      o_timeout <= 1'b0;
      if (tick && (tmr != '1)) tmr <= tmr + 32'd1;

      if (sensor_phase && !adv && timed_out) begin
        state     <= ST_IDLE;
        tmr       <= '0;
        drive_low <= 1'b0;
        o_timeout <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (i_start || poll_due) begin
              mode_q    <= i_mode;
              drive_low <= 1'b1;
              state     <= ST_START_LO;
              tmr       <= '0;
            end
          end
          ST_START_LO: begin
            if (tmr >= start_us) begin
              drive_low <= 1'b0;
              state     <= ST_START_REL;
              tmr       <= '0;
            end
          end
          ST_START_REL: begin
            if (adv) begin
              state <= ST_RESP_LO;
              tmr   <= '0;
            end
          end
          ST_RESP_LO: begin
            if (adv) begin
              state <= ST_RESP_HI;
              tmr   <= '0;
            end
          end
          ST_RESP_HI: begin
            if (adv) begin
              bit_cnt <= '0;
              state   <= ST_BIT_LO;
              tmr     <= '0;
            end
          end
          ST_BIT_LO: begin
            if (adv) begin
              state <= ST_BIT_HI;
              tmr   <= '0;
            end
          end
          ST_BIT_HI: begin
            if (adv) begin
              shreg   <= {shreg[38:0], (tmr > B1_US)};
              bit_cnt <= bit_cnt + 6'd1;
              state   <= (bit_cnt == 6'd39) ? ST_CHECK : ST_BIT_LO;
              tmr     <= '0;
            end
          end
          ST_CHECK: begin
            if (sum == b0) begin
              o_humi  <= humi_next;
              o_temp  <= temp_next;
              o_valid <= 1'b1;
            end else begin
              o_crc_err <= 1'b1;
            end
            state <= ST_IDLE;
            tmr   <= '0;
          end
          default: begin
            state <= ST_IDLE;
            tmr   <= '0;
          end
        endcase
      end
    end
  end

  assign o_state = state;
  assign o_busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_dht_poll.sv
// tb/tb_dht_poll.sv - scoreboard bench for dht_poll with a behavioural sensor model
module tb_dht_poll;
  import dht_pkg::*;

  localparam int unsigned CLK_HZ     = 1_000_000;
  localparam int unsigned POLL_MS    = 5;
  localparam int unsigned TIMEOUT_US = 200;
  localparam int unsigned BIT1_US    = 50;

  localparam logic [2:0] K_VALID = 3'b001;
  localparam logic [2:0] K_CRC   = 3'b010;
  localparam logic [2:0] K_TO    = 3'b100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_mode, i_start;
  wire         bus;
  logic        sens_low;
  bit          sensor_abort;
  logic [15:0] o_humi, o_temp;
  logic        o_valid, o_crc_err, o_timeout, o_busy;
  logic [2:0]  o_state;

  pullup (bus);
  assign bus = sens_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  dht_poll #(
    .CLK_HZ(CLK_HZ), .POLL_MS(POLL_MS), .TIMEOUT_US(TIMEOUT_US), .BIT1_US(BIT1_US)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_mode(i_mode), .i_start(i_start), .io_data(bus),
    .o_humi(o_humi), .o_temp(o_temp), .o_valid(o_valid), .o_crc_err(o_crc_err),
    .o_timeout(o_timeout), .o_busy(o_busy), .o_state(o_state)
  );

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [2:0] kind;
    int         humi;
    int         temp;
  } exp_t;

  exp_t exp_q[$];
  int   mdl_humi = 0;
  int   mdl_temp = 0;

  task automatic check_eq(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
    checks++;
    if (act >= lo && act <= hi) passes++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  // Reference model: decode a 40-bit frame straight from the sensor datasheet rules.
  task automatic expect_frame(input logic mode, input logic [39:0] f);
    int   b4, b3, b2, b1, b0, raw;
    exp_t e;
    b4 = int'(f[39:32]);
    b3 = int'(f[31:24]);
    b2 = int'(f[23:16]);
    b1 = int'(f[15:8]);
    b0 = int'(f[7:0]);
    if ((b4 + b3 + b2 + b1) % 256 != b0) begin
      e.kind = K_CRC;
    end else begin
      e.kind = K_VALID;
      if (mode == MODE_DHT11) begin
        mdl_humi = b4;
        mdl_temp = (b2 >= 128) ? b2 - 256 : b2;
      end else begin
        mdl_humi = b4 * 256 + b3;
        raw      = (b2 % 128) * 256 + b1;
        mdl_temp = (b2 >= 128) ? -raw : raw;
      end
    end
    e.humi = mdl_humi;
    e.temp = mdl_temp;
    exp_q.push_back(e);
  endtask

  task automatic expect_timeout();
    exp_t e;
    e.kind = K_TO;
    e.humi = mdl_humi;
    e.temp = mdl_temp;
    exp_q.push_back(e);
  endtask

  // Monitor: every strobe cycle consumes one expected event.
  always @(negedge clk) begin
    if (rst_n && (o_valid || o_crc_err || o_timeout)) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_strobe: got kind %b, expected no strobe", {o_timeout, o_crc_err, o_valid});
      end else begin
        exp_t              e;
        logic signed [15:0] t;
        e = exp_q.pop_front();
        t = o_temp;
        check_eq("strobe_kind", {o_timeout, o_crc_err, o_valid}, e.kind);
        check_eq("humi", o_humi, e.humi);
        check_eq("temp", t, e.temp);
      end
    end
  end

  task automatic hold(input logic low, input int n);
    sens_low = low;
    for (int i = 0; i < n && !sensor_abort; i++) @(negedge clk);
  endtask

  // Sensor model: waits for the host start pulse, measures it, then answers with f.
  task automatic sensor_respond(input logic [39:0] f, input bit silent, input int min_low, input int bound);
    int n;
    n = 0;
    while (bus !== 1'b0 && n < bound && !sensor_abort) begin
      @(negedge clk);
      n++;
    end
    if (sensor_abort) begin
      sens_low = 1'b0;
      return;
    end
    check_eq("start_seen", (bus === 1'b0), 1);
    if (bus !== 1'b0) return;
    n = 0;
    while (bus === 1'b0 && n < 30000 && !sensor_abort) begin
      @(negedge clk);
      n++;
    end
    if (sensor_abort) begin
      sens_low = 1'b0;
      return;
    end
    check_range("start_low_len", n, min_low, min_low + 10);
    if (silent) return;
    hold(1'b0, $urandom_range(20, 40));
    hold(1'b1, 80);
    hold(1'b0, 80);
    for (int i = 39; i >= 0; i--) begin
      hold(1'b1, $urandom_range(20, 40));
      hold(1'b0, f[i] ? $urandom_range(60, 90) : $urandom_range(15, 40));
    end
    hold(1'b1, 50);
    sens_low = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (o_busy && n < bound) begin
      @(negedge clk);
      n++;
    end
    check_eq("idle_reached", o_busy, 0);
  endtask

  task automatic run_txn(input logic mode, input logic [39:0] f);
    i_mode = mode;
    expect_frame(mode, f);
    pulse_start();
    i_mode = ~mode;
    sensor_respond(f, 1'b0, (mode == MODE_DHT11) ? 20000 : 2000, 10);
    wait_idle(500);
    @(negedge clk);
    check_eq("idle_after_txn", o_state, ST_IDLE);
  endtask

  function automatic logic [39:0] rand_frame(input bit corrupt);
    logic [7:0] b4, b3, b2, b1, b0;
    b4 = 8'($urandom_range(0, 255));
    b3 = 8'($urandom_range(0, 255));
    b2 = 8'($urandom_range(0, 255));
    b1 = 8'($urandom_range(0, 255));
    b0 = b4 + b3 + b2 + b1;
    if (corrupt) b0 = b0 + 8'($urandom_range(1, 255));
    return {b4, b3, b2, b1, b0};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          n;
    int          busy_cnt;
    logic [39:0] f;

    rst_n        = 1'b0;
    i_mode       = 1'b0;
    i_start      = 1'b0;
    sens_low     = 1'b0;
    sensor_abort = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check_eq("rst_state", o_state, ST_IDLE);
    check_eq("rst_busy", o_busy, 0);
    check_eq("rst_humi", o_humi, 0);
    check_eq("rst_temp", o_temp, 0);
    check_eq("rst_strobes", {o_valid, o_crc_err, o_timeout}, 0);
    check_eq("rst_bus_released", (bus === 1'b1), 1);

    run_txn(MODE_DHT11, 40'h37_00_18_00_4F);
    run_txn(MODE_DHT11, 40'h37_00_18_00_50);

    f = 40'h02_8C_80_65_73;
    i_mode = MODE_DHT22;
    expect_frame(MODE_DHT22, f);
    pulse_start();
    fork
      sensor_respond(f, 1'b0, 2000, 10);
      begin
        repeat (3000) @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
      end
    join
    wait_idle(500);
    busy_cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (o_busy) busy_cnt++;
    end
    check_eq("start_while_busy_dropped", busy_cnt, 0);

    for (int k = 0; k < 2; k++) begin
      run_txn(MODE_DHT22, rand_frame($urandom_range(0, 1) == 1));
    end

    i_mode = MODE_DHT22;
    expect_timeout();
    pulse_start();
    sensor_respond('0, 1'b1, 2000, 10);
    n = 0;
    while (!o_timeout && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check_range("timeout_after_release", n, 195, 215);
    @(negedge clk);
    check_eq("timeout_busy_fall", o_busy, 0);

    expect_timeout();
    n = 0;
    while (!o_busy && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check_range("poll_retry_delay", n, 4990, 5010);
    sensor_respond('0, 1'b1, 2000, 10);
    wait_idle(500);

    i_mode = MODE_DHT22;
    f = rand_frame(1'b0);
    pulse_start();
    fork
      sensor_respond(f, 1'b0, 2000, 10);
      begin
        n = 0;
        while (o_state != ST_BIT_HI && n < 5000) begin
          @(negedge clk);
          n++;
        end
        check_eq("reached_bit_hi", o_state, ST_BIT_HI);
        #2;
        rst_n        = 1'b0;
        sensor_abort = 1'b1;
        mdl_humi     = 0;
        mdl_temp     = 0;
        #1;
        check_eq("bit_hi_rst_state", o_state, ST_IDLE);
        check_eq("bit_hi_rst_busy", o_busy, 0);
        check_eq("bit_hi_rst_humi", o_humi, 0);
        check_eq("bit_hi_rst_temp", o_temp, 0);
      end
    join
    sensor_abort = 1'b0;
    sens_low     = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("bit_hi_rst_bus", (bus === 1'b1), 1);

    i_mode = MODE_DHT22;
    pulse_start();
    repeat (100) @(negedge clk);
    check_eq("start_lo_driven", (bus === 1'b0), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_bus_release", (bus === 1'b1), 1);
    check_eq("async_rst_busy", o_busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    repeat (20) @(negedge clk);
    check_eq("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
